// File: rtl/gpu_fill_sched.sv
// Rectangle fill command scheduler: queues fill commands, normalizes and clips
// them to the screen, and launches the fill engine one command at a time.
module gpu_fill_sched #(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int COLOR_BITS  = 24,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 1048576
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [WIDTH_BITS-1:0]  cmd_x1_i,
    input  logic [WIDTH_BITS-1:0]  cmd_x2_i,
    input  logic [HEIGHT_BITS-1:0] cmd_y1_i,
    input  logic [HEIGHT_BITS-1:0] cmd_y2_i,
    input  logic [COLOR_BITS-1:0]  cmd_color_i,
    output logic                   fr_start_o,
    output logic [WIDTH_BITS-1:0]  fr_x1_o,
    output logic [WIDTH_BITS-1:0]  fr_x2_o,
    output logic [HEIGHT_BITS-1:0] fr_y1_o,
    output logic [HEIGHT_BITS-1:0] fr_y2_o,
    input  logic                   fr_done_i,
    output logic [COLOR_BITS-1:0]  color_o,
    output logic                   cmd_done_o,
    output logic [7:0]             skip_cnt_o,
    output logic                   err_o,
    output logic                   idle_o
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int EW  = 2 * WIDTH_BITS + 2 * HEIGHT_BITS + COLOR_BITS;
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH_BITS:0]      LP_SCREEN_W = (WIDTH_BITS + 1)'(SCREEN_W);
    localparam logic [HEIGHT_BITS:0]     LP_SCREEN_H = (HEIGHT_BITS + 1)'(SCREEN_H);
    localparam logic [WIDTH_BITS-1:0]    LP_X_LAST   = WIDTH_BITS'(SCREEN_W - 1);
    localparam logic [HEIGHT_BITS-1:0]   LP_Y_LAST   = HEIGHT_BITS'(SCREEN_H - 1);
    localparam logic [WDW-1:0]           LP_WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [CW-1:0]            LP_DEPTH    = CW'(DEPTH);

    localparam int OFF_Y2 = COLOR_BITS;
    localparam int OFF_X2 = OFF_Y2 + HEIGHT_BITS;
    localparam int OFF_Y1 = OFF_X2 + WIDTH_BITS;
    localparam int OFF_X1 = OFF_Y1 + HEIGHT_BITS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_timeout;

    logic [EW-1:0]          r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_count_next;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    logic [EW-1:0]          w_head;
    logic [WIDTH_BITS-1:0]  w_hx1, w_hx2, w_xmin, w_xmax, w_xmax_clip;
    logic [HEIGHT_BITS-1:0] w_hy1, w_hy2, w_ymin, w_ymax, w_ymax_clip;
    logic [COLOR_BITS-1:0]  w_hcolor;
    logic                   w_skip;

    logic [WDW-1:0]         r_wd;
    logic                   r_fr_start;
    logic [WIDTH_BITS-1:0]  r_fr_x1, r_fr_x2;
    logic [HEIGHT_BITS-1:0] r_fr_y1, r_fr_y2;
    logic [COLOR_BITS-1:0]  r_color;
    logic                   r_cmd_done;
    logic [7:0]             r_skip_cnt;
    logic                   r_err;
    logic                   r_idle;

    // Ready is held low during reset so no command slips in while the queue is flushed.
    assign w_full      = (r_count == LP_DEPTH);
    assign w_empty     = (r_count == '0);
    assign cmd_ready_o = !w_full && !rst;
    assign w_push      = cmd_valid_i && cmd_ready_o;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_x1_i, cmd_y1_i, cmd_x2_i, cmd_y2_i, cmd_color_i};
        end
    end

    // Head is read combinationally so IDLE can decide and pop in the same cycle.
    assign w_head   = r_mem[r_rd_ptr];
    assign w_hx1    = w_head[OFF_X1 +: WIDTH_BITS];
    assign w_hy1    = w_head[OFF_Y1 +: HEIGHT_BITS];
    assign w_hx2    = w_head[OFF_X2 +: WIDTH_BITS];
    assign w_hy2    = w_head[OFF_Y2 +: HEIGHT_BITS];
    assign w_hcolor = w_head[COLOR_BITS-1:0];

    assign w_xmin      = (w_hx1 < w_hx2) ? w_hx1 : w_hx2;
    assign w_xmax      = (w_hx1 < w_hx2) ? w_hx2 : w_hx1;
    assign w_ymin      = (w_hy1 < w_hy2) ? w_hy1 : w_hy2;
    assign w_ymax      = (w_hy1 < w_hy2) ? w_hy2 : w_hy1;
    assign w_xmax_clip = (w_xmax > LP_X_LAST) ? LP_X_LAST : w_xmax;
    assign w_ymax_clip = (w_ymax > LP_Y_LAST) ? LP_Y_LAST : w_ymax;
    assign w_skip      = ({1'b0, w_xmin} >= LP_SCREEN_W) || ({1'b0, w_ymin} >= LP_SCREEN_H);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !w_skip) begin
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT: begin
                if (fr_done_i) begin
                    w_state_next = S_IDLE;
                end else if (r_wd == LP_WD_LAST) begin
                    w_state_next = S_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wd       <= '0;
            r_fr_start <= 1'b0;
            r_fr_x1    <= '0;
            r_fr_x2    <= '0;
            r_fr_y1    <= '0;
            r_fr_y2    <= '0;
            r_color    <= '0;
            r_cmd_done <= 1'b0;
            r_skip_cnt <= '0;
            r_err      <= 1'b0;
            r_idle     <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_idle     <= (w_state_next == S_IDLE) && (w_count_next == '0);
            r_fr_start <= (r_state == S_LAUNCH);
            r_cmd_done <= (r_state == S_WAIT) && fr_done_i;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_skip) begin
                    if (r_skip_cnt != 8'hFF) begin
                        r_skip_cnt <= r_skip_cnt + 8'd1;
                    end
                end else begin
                    r_fr_x1 <= w_xmin;
                    r_fr_x2 <= w_xmax_clip;
                    r_fr_y1 <= w_ymin;
                    r_fr_y2 <= w_ymax_clip;
                    r_color <= w_hcolor;
                end
            end
            if (r_state == S_LAUNCH) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign fr_start_o = r_fr_start;
    assign fr_x1_o    = r_fr_x1;
    assign fr_x2_o    = r_fr_x2;
    assign fr_y1_o    = r_fr_y1;
    assign fr_y2_o    = r_fr_y2;
    assign color_o    = r_color;
    assign cmd_done_o = r_cmd_done;
    assign skip_cnt_o = r_skip_cnt;
    assign err_o      = r_err;
    assign idle_o     = r_idle;

endmodule

// File: tb/tb_gpu_fill_sched.sv
// Scoreboard bench for gpu_fill_sched: stimulus queues expected launches,
// a negedge monitor checks every fr_start_o pulse against the queue head.
module tb_gpu_fill_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [9:0]  cmd_x1_i = '0, cmd_x2_i = '0;
    logic [8:0]  cmd_y1_i = '0, cmd_y2_i = '0;
    logic [23:0] cmd_color_i = '0;
    logic        fr_start_o;
    logic [9:0]  fr_x1_o, fr_x2_o;
    logic [8:0]  fr_y1_o, fr_y2_o;
    logic        fr_done_i = 1'b0;
    logic [23:0] color_o;
    logic        cmd_done_o;
    logic [7:0]  skip_cnt_o;
    logic        err_o;
    logic        idle_o;

    gpu_fill_sched #(
        .WIDTH_BITS(10), .HEIGHT_BITS(9), .SCREEN_W(640), .SCREEN_H(480),
        .COLOR_BITS(24), .DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_x1_i(cmd_x1_i), .cmd_x2_i(cmd_x2_i),
        .cmd_y1_i(cmd_y1_i), .cmd_y2_i(cmd_y2_i),
        .cmd_color_i(cmd_color_i),
        .fr_start_o(fr_start_o),
        .fr_x1_o(fr_x1_o), .fr_x2_o(fr_x2_o),
        .fr_y1_o(fr_y1_o), .fr_y2_o(fr_y2_o),
        .fr_done_i(fr_done_i),
        .color_o(color_o), .cmd_done_o(cmd_done_o),
        .skip_cnt_o(skip_cnt_o), .err_o(err_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    logic [61:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_starts = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one command; when launch is set the expected normalized/clipped result is queued.
    task automatic send(input int x1, input int y1, input int x2, input int y2, input int col,
                        input bit launch, input int ex1, input int ex2, input int ey1, input int ey2);
        int k;
        cmd_x1_i    = 10'(x1);
        cmd_y1_i    = 9'(y1);
        cmd_x2_i    = 10'(x2);
        cmd_y2_i    = 9'(y2);
        cmd_color_i = 24'(col);
        cmd_valid_i = 1'b1;
        k = 0;
        while (!cmd_ready_o && k < 64) begin
            tick;
            k++;
        end
        if (!cmd_ready_o) begin
            check("send_accept", 64'(cmd_ready_o), 64'd1);
            cmd_valid_i = 1'b0;
        end else begin
            if (launch) exp_q.push_back({10'(ex1), 10'(ex2), 9'(ey1), 9'(ey2), 24'(col)});
            @(posedge clk);
            #1;
            cmd_valid_i = 1'b0;
            $display("send (%0d,%0d)-(%0d,%0d) color=%06h launch=%0d", x1, y1, x2, y2, col, launch);
        end
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (!fr_start_o && k < 40) begin
            tick;
            k++;
        end
        check(name, 64'(fr_start_o), 64'd1);
    endtask

    // Done pulse sampled at edge d: cmd_done right after d, next launch visible after d+2.
    task automatic done_pulse(input bit next_launch, input string name);
        fr_done_i = 1'b1;
        tick;
        fr_done_i = 1'b0;
        check({name, "_cmd_done"}, 64'(cmd_done_o), 64'd1);
        tick;
        check({name, "_gap1_start"}, 64'(fr_start_o), 64'd0);
        check({name, "_done_one_cycle"}, 64'(cmd_done_o), 64'd0);
        tick;
        if (next_launch) check({name, "_gap2_start"}, 64'(fr_start_o), 64'd1);
        else             check({name, "_idle"}, 64'(idle_o), 64'd1);
        $display("done %s next_launch=%0d", name, next_launch);
    endtask

    always @(negedge clk) begin
        if (!rst && fr_start_o) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                check("unexpected_start", 64'(fr_start_o), 64'd0);
            end else begin
                logic [61:0] e;
                e = exp_q.pop_front();
                check("launch_fields", 64'({fr_x1_o, fr_x2_o, fr_y1_o, fr_y2_o, color_o}), 64'(e));
                $display("start x=%0d..%0d y=%0d..%0d color=%06h", fr_x1_o, fr_x2_o, fr_y1_o, fr_y2_o, color_o);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        tick;
        tick;
        check("rst_ready_low", 64'(cmd_ready_o), 64'd0);
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_start", 64'(fr_start_o), 64'd0);
        check("rst_cmd_done", 64'(cmd_done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_skip", 64'(skip_cnt_o), 64'd0);
        check("rst_fr_bounds", 64'({fr_x1_o, fr_x2_o, fr_y1_o, fr_y2_o}), 64'd0);
        check("rst_color", 64'(color_o), 64'd0);
        rst = 1'b0;
        tick;
        check("ready_after_rst", 64'(cmd_ready_o), 64'd1);

        // Single command: start two edges after acceptance.
        send(3, 2, 8, 6, 'hFF0000, 1, 3, 8, 2, 6);
        check("lat_t0_start", 64'(fr_start_o), 64'd0);
        tick;
        check("lat_t1_start", 64'(fr_start_o), 64'd0);
        tick;
        check("lat_t2_start", 64'(fr_start_o), 64'd1);
        done_pulse(0, "single");

        send(8, 6, 3, 2, 'h00FF00, 1, 3, 8, 2, 6);
        wait_start("swap_start");
        done_pulse(0, "swap");

        send(600, 400, 1000, 500, 'h0000FF, 1, 600, 639, 400, 479);
        wait_start("clip_start");
        done_pulse(0, "clip");

        // Off-screen commands: counted, never launched, outputs untouched.
        send(700, 10, 900, 20, 'hABCDEF, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("skip_x_count", 64'(skip_cnt_o), 64'd1);
        check("skip_idle", 64'(idle_o), 64'd1);
        send(10, 480, 20, 500, 'hABCDEF, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("skip_y_count", 64'(skip_cnt_o), 64'd2);
        for (int i = 0; i < 253; i++) send(700, 5, 640 + (i % 384), 7, i, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("skip_255", 64'(skip_cnt_o), 64'd255);
        send(1023, 0, 640, 0, 'h123456, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("skip_saturate", 64'(skip_cnt_o), 64'd255);
        check("skip_keeps_color", 64'(color_o), 64'h0000FF);
        check("skip_keeps_bounds", 64'({fr_x1_o, fr_x2_o}), 64'({10'd600, 10'd639}));

        // FIFO fill with the engine stalled.
        send(10, 10, 20, 20, 'h111111, 1, 10, 20, 10, 20);
        wait_start("fifo_a_start");
        send(5, 5, 1, 1, 'h222222, 1, 1, 5, 1, 5);
        send(639, 479, 639, 479, 'h333333, 1, 639, 639, 479, 479);
        send(0, 0, 1023, 511, 'h444444, 1, 0, 639, 0, 479);
        send(100, 300, 50, 200, 'h555555, 1, 50, 100, 200, 300);
        check("fifo_full_ready", 64'(cmd_ready_o), 64'd0);
        cmd_x1_i = 10'd1; cmd_y1_i = 9'd1; cmd_x2_i = 10'd2; cmd_y2_i = 9'd2;
        cmd_color_i = 24'h999999;
        cmd_valid_i = 1'b1;
        tick;
        check("sixth_offer_ready", 64'(cmd_ready_o), 64'd0);
        cmd_valid_i = 1'b0;
        done_pulse(1, "retire_a");
        done_pulse(1, "retire_b");
        done_pulse(1, "retire_c");
        done_pulse(1, "retire_d");
        done_pulse(0, "retire_e");

        // Watchdog: 16 WAIT_DONE cycles, then the queued command launches.
        send(1, 1, 2, 2, 'h666666, 1, 1, 2, 1, 2);
        send(3, 3, 4, 4, 'h777777, 1, 3, 4, 3, 4);
        wait_start("to_g_start");
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (cmd_done_o) saw_done = 1'b1;
        end
        check("to_err_before", 64'(err_o), 64'd0);
        tick;
        if (cmd_done_o) saw_done = 1'b1;
        check("to_err_set", 64'(err_o), 64'd1);
        check("to_no_cmd_done", 64'(saw_done), 64'd0);
        tick;
        check("to_next_gap1", 64'(fr_start_o), 64'd0);
        tick;
        check("to_next_launch", 64'(fr_start_o), 64'd1);
        done_pulse(0, "to_h");
        check("err_sticky", 64'(err_o), 64'd1);

        // Reset while waiting with two commands queued.
        send(7, 7, 9, 9, 'h888888, 1, 7, 9, 7, 9);
        send(11, 11, 12, 12, 'h999999, 1, 11, 12, 11, 12);
        send(13, 13, 14, 14, 'hAAAAAA, 1, 13, 14, 13, 14);
        wait_start("rst_i_start");
        tick;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(cmd_ready_o), 64'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        check("rst_mid_idle", 64'(idle_o), 64'd1);
        check("rst_mid_err", 64'(err_o), 64'd0);
        check("rst_mid_skip", 64'(skip_cnt_o), 64'd0);
        check("rst_mid_fields", 64'({fr_x1_o, fr_x2_o, fr_y1_o, fr_y2_o, color_o}), 64'd0);
        check("rst_mid_start", 64'(fr_start_o), 64'd0);
        $display("reset asserted in WAIT_DONE");
        fr_done_i = 1'b1;
        tick;
        fr_done_i = 1'b0;
        check("late_done_ignored", 64'(cmd_done_o), 64'd0);
        tick;
        tick;
        check("post_rst_idle", 64'(idle_o), 64'd1);
        check("post_rst_ready", 64'(cmd_ready_o), 64'd1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("start_count", 64'(n_starts), 64'd11);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpu_fill_sched.md
# gpu_fill_sched

Command scheduler for the rectangle fill engine (`gpu_fill_rect`). It queues rectangle fill commands from the command decoder in a small FIFO and normalizes and clips each one to the screen. It then launches the fill engine one command at a time using a start/done handshake and supplies the fill color for the pixel stream the engine produces. A watchdog flags an engine that never completes.

## Interface
- `WIDTH_BITS`, 10: x coordinate width.
- `HEIGHT_BITS`, 9: y coordinate width.
- `SCREEN_W`, 640: visible width; valid x is 0..`SCREEN_W`-1.
- `SCREEN_H`, 480: visible height; valid y is 0..`SCREEN_H`-1.
- `COLOR_BITS`, 24: fill color width.
- `DEPTH`, 4: command FIFO depth; must be a power of 2 and at least 2.
- `TIMEOUT`, 1048576: maximum WAIT_DONE cycles before error.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: FIFO can accept; equals !full, and is forced 0 while `rst`=1.
- `cmd_x1_i`, `cmd_x2_i` in `WIDTH_BITS`: corner x, any order, inclusive.
- `cmd_y1_i`, `cmd_y2_i` in `HEIGHT_BITS`: corner y, any order, inclusive.
- `cmd_color_i` in `COLOR_BITS`: fill color.
- `fr_start_o` out 1: one-cycle launch pulse to the fill engine.
- `fr_x1_o`, `fr_x2_o` out `WIDTH_BITS`: normalized, clipped x bounds (x1≤x2).
- `fr_y1_o`, `fr_y2_o` out `HEIGHT_BITS`: normalized, clipped y bounds (y1≤y2).
- `fr_done_i` in 1: engine finished, one-cycle pulse.
- `color_o` out `COLOR_BITS`: color of the active command.
- `cmd_done_o` out 1: one-cycle pulse per completed launched command.
- `skip_cnt_o` out 8: count of fully off-screen commands; saturates at 255.
- `err_o` out 1: sticky watchdog timeout flag.
- `idle_o` out 1: high when state is IDLE and the FIFO is empty.

## Operation
- FIFO: a push occurs on any cycle with `cmd_valid_i`&&`cmd_ready_o`; each entry is {x1,y1,x2,y2,color}. When full, `cmd_ready_o`=0 and no push occurs. A push and a pop in the same cycle are both legal, and occupancy is unchanged.
- FSM states: IDLE, LAUNCH, WAIT_DONE.
- IDLE: when the FIFO is non-empty, pop the head and register the processed command.
  - Normalize: xmin=min(x1,x2), xmax=max; same for y.
  - Skip: if xmin≥`SCREEN_W` or ymin≥`SCREEN_H`, discard the command, increment `skip_cnt_o` (saturating) and stay in IDLE. The `fr_*` outputs and `color_o` are not updated.
  - Otherwise clip: xmax=min(xmax,`SCREEN_W`-1), ymax=min(ymax,`SCREEN_H`-1). Load the `fr_*` outputs and `color_o`, then go to LAUNCH.
- LAUNCH: `fr_start_o`=1 for exactly this cycle; clear the watchdog counter; go to WAIT_DONE.
- WAIT_DONE:
  - On `fr_done_i`=1, go to IDLE; `cmd_done_o` is registered high for the next cycle.
  - Otherwise increment the watchdog. When it reaches `TIMEOUT`-1 without done, set `err_o` and go to IDLE. No `cmd_done_o` is issued in that case.
- `fr_done_i` is ignored in IDLE and LAUNCH.
- `fr_*` outputs and `color_o` hold from LAUNCH until the next non-skipped pop.
- Coordinates are unsigned. Comparisons are at full port width. No wrap-around; clipping only reduces values.

## Timing
- Reset (`rst`=1 at an edge) sets:
  - FIFO empty; state IDLE.
  - `fr_start_o`=0, `cmd_done_o`=0, `err_o`=0, `skip_cnt_o`=0.
  - `fr_*` outputs=0, `color_o`=0.
  - `idle_o`=1 after the edge.
- Reset in LAUNCH or WAIT_DONE aborts the command. No `cmd_done_o` is issued, and the queued commands are lost.
- Latency: a command accepted at edge t into an empty idle block is popped at edge t+1. `fr_start_o` is high in cycle t+2 (between edges t+2 and t+3).
- Back-to-back: with `fr_done_i` sampled at edge d and the FIFO non-empty, `cmd_done_o` is high and IDLE pops during cycle d+1. The next `fr_start_o` is high in cycle d+2, so the gap is 2 cycles.
- Skipped commands take one IDLE cycle each.
- `err_o` clears only on reset.
- `cmd_ready_o` is combinational from FIFO occupancy and `rst`. All other outputs are registered.

## Test plan
- Single command (3,2)-(8,6) with color 0xFF0000 → `fr_start_o` high 2 cycles after acceptance, outputs x1=3,x2=8,y1=2,y2=6, `color_o`=0xFF0000; `fr_done_i` pulse → `cmd_done_o` next cycle, then `idle_o`=1.
- Swapped corners (8,6)-(3,2) → same normalized outputs; clip case (600,400)-(1000,500) → x 600..639, y 400..479.
- Off-screen (700,10)-(900,20) → no `fr_start_o`, `skip_cnt_o`=1; 256 off-screen commands → `skip_cnt_o` stays at 255.
- Push 5 commands with the engine stalled and DEPTH=4 → one command in flight, then 4 accepted, `cmd_ready_o`=0 on the 6th offer. Done pulses → commands retire in FIFO order with 2-cycle start spacing.
- TIMEOUT=16, no `fr_done_i` → `err_o`=1 after 16 WAIT_DONE cycles, no `cmd_done_o`, next queued command launches.
- `rst` asserted in WAIT_DONE with 2 commands queued → all outputs return to reset values, `idle_o`=1, and a late `fr_done_i` produces no `cmd_done_o`.
